// File: rtl/irrigation_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_pkg
// Description : Shared state encoding and field widths for the irrigation
//               sequencer and its prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package irrigation_pkg;

    localparam int c_DUR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } irr_state_t;

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk into irrigation time units; flags the last count.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic wrap
);

    localparam int                 c_CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_CNT_W'(1);
        end
    end

    // High while the count sits on its last value; the enabled edge that
    // leaves this value is the wrap that retires one time unit.
    assign wrap = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : irrigation_sequencer
// Description : Valve sequencing FSM with remaining-time counter, water
//               supply pause and abort handling.
// Revision    : 1.0 - initial release
// ============================================================================
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [c_DUR_W-1:0] duration,
    input  logic               abort,
    input  logic               water_ok,
    output logic               valve,
    output logic               busy,
    output logic [c_DUR_W-1:0] remaining,
    output logic               done,
    output logic               fault
);

    logic [1:0]         r_rst_sync;
    logic               w_rst_n;
    irr_state_t         r_state;
    logic               r_valve;
    logic               r_busy;
    logic [c_DUR_W-1:0] r_remaining;
    logic               r_done;
    logic               r_fault;
    logic               w_wrap;
    logic               w_tick_en;
    logic               w_tick_clr;

    // Assertion reaches every flop at once; release is delayed two edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // The cycle in which water loss is seen still had the valve open, so it
    // counts; only a wrap on that same cycle is held back, keeping remaining.
    assign w_tick_en  = (r_state == ST_RUN) && !abort && (water_ok || !w_wrap);
    assign w_tick_clr = !((r_state == ST_RUN) || (r_state == ST_PAUSE)) || abort;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (w_rst_n),
        .enable (w_tick_en),
        .clear  (w_tick_clr),
        .wrap   (w_wrap)
    );

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_valve     <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (duration != '0) begin
                            r_state     <= ST_RUN;
                            r_remaining <= duration;
                            r_valve     <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state     <= ST_DONE;
                            r_remaining <= '0;
                        end
                    end
                end

                ST_RUN: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_valve     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fault     <= 1'b0;
                        r_remaining <= '0;
                    end else if (!water_ok) begin
                        r_state <= ST_PAUSE;
                        r_valve <= 1'b0;
                        r_fault <= 1'b1;
                    end else if (w_wrap) begin
                        if (r_remaining <= c_DUR_W'(1)) begin
                            r_state     <= ST_DONE;
                            r_remaining <= '0;
                            r_valve     <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_remaining <= r_remaining - c_DUR_W'(1);
                        end
                    end
                end

                ST_PAUSE: begin
                    if (abort) begin
                        r_state     <= ST_IDLE;
                        r_valve     <= 1'b0;
                        r_busy      <= 1'b0;
                        r_fault     <= 1'b0;
                        r_remaining <= '0;
                    end else if (water_ok) begin
                        r_state <= ST_RUN;
                        r_valve <= 1'b1;
                        r_fault <= 1'b0;
                    end
                end

                // The registered done pulse appears on the cycle after DONE.
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b1;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign valve     = r_valve;
    assign busy      = r_busy;
    assign remaining = r_remaining;
    assign done      = r_done;
    assign fault     = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_irrigation_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_irrigation_sequencer
// Description : Scoreboard bench for irrigation_sequencer with TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irrigation_sequencer;
    import irrigation_pkg::*;

    localparam int c_TD = 4;

    logic       clk      = 1'b0;
    logic       rst      = 1'b0;
    logic       start    = 1'b0;
    logic [3:0] duration = 4'd0;
    logic       abort    = 1'b0;
    logic       water_ok = 1'b1;
    logic       valve;
    logic       busy;
    logic [3:0] remaining;
    logic       done;
    logic       fault;

    int         checks    = 0;
    int         failures  = 0;
    int         valve_cyc = 0;
    int         fault_cyc = 0;
    int         done_cyc  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_snap = 8'h00;
    logic [7:0] cur_snap;
    logic [7:0] exp_snap;
    logic       mon_en    = 1'b0;
    int         v0, f0, d0;

    irrigation_sequencer #(
        .TICK_DIV (c_TD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .duration  (duration),
        .abort     (abort),
        .water_ok  (water_ok),
        .valve     (valve),
        .busy      (busy),
        .remaining (remaining),
        .done      (done),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] snap(input logic v, input logic b, input logic f,
                                        input logic d, input logic [3:0] r);
        return {v, b, f, d, r};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic v, input logic b, input logic f,
                        input logic d, input logic [3:0] r);
        exp_q.push_back(snap(v, b, f, d, r));
    endtask

    task automatic mark();
        v0 = valve_cyc;
        f0 = fault_cyc;
        d0 = done_cyc;
    endtask

    // Monitor: every change of the output vector pops one expected entry.
    initial begin
        forever begin
            @(negedge clk);
            cur_snap = {valve, busy, fault, done, remaining};
            if (valve === 1'b1) valve_cyc++;
            if (fault === 1'b1) fault_cyc++;
            if (done === 1'b1)  done_cyc++;
            if (mon_en && (cur_snap !== prev_snap)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'(cur_snap), int'(prev_snap));
                end else begin
                    exp_snap = exp_q.pop_front();
                    check("output_vector", int'(cur_snap), int'(exp_snap));
                end
            end
            prev_snap = cur_snap;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({valve, busy, fault, done, remaining}), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Normal cycle, duration 3
        mark();
        push(1, 1, 0, 0, 4'd3); push(1, 1, 0, 0, 4'd2); push(1, 1, 0, 0, 4'd1);
        push(0, 0, 0, 0, 4'd0); push(0, 0, 0, 1, 4'd0); push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd3;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        check("normal_first_remaining", int'(remaining), 3);
        repeat (16) @(negedge clk);
        #1;
        check("normal_valve_cycles", valve_cyc - v0, 12);
        check("normal_done_pulses", done_cyc - d0, 1);
        check("normal_busy_after", int'(busy), 0);
        check("normal_queue_drained", exp_q.size(), 0);

        // Zero duration, with abort held through DONE
        mark();
        push(0, 0, 0, 1, 4'd0); push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd0; abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_done_early", int'(done), 0);
        @(negedge clk);
        check("zero_done_pulse", int'(done), 1);
        abort = 1'b0;
        @(negedge clk);
        check("zero_done_width", int'(done), 0);
        repeat (3) @(negedge clk);
        #1;
        check("zero_valve_cycles", valve_cyc - v0, 0);
        check("zero_queue_drained", exp_q.size(), 0);

        // Water loss for 5 cycles after 2 RUN cycles, duration 2
        mark();
        push(1, 1, 0, 0, 4'd2); push(0, 1, 1, 0, 4'd2); push(1, 1, 0, 0, 4'd2);
        push(1, 1, 0, 0, 4'd1); push(0, 0, 0, 0, 4'd0); push(0, 0, 0, 1, 4'd0);
        push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd2;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        @(negedge clk);
        water_ok = 1'b0;
        repeat (2) @(negedge clk);
        check("pause_fault", int'(fault), 1);
        check("pause_valve", int'(valve), 0);
        check("pause_remaining", int'(remaining), 2);
        repeat (3) @(negedge clk);
        water_ok = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("pause_valve_cycles", valve_cyc - v0, 8);
        check("pause_fault_cycles", fault_cyc - f0, 5);
        check("pause_done_pulses", done_cyc - d0, 1);
        check("pause_queue_drained", exp_q.size(), 0);

        // Abort after 6 RUN cycles, duration 5, with an ignored restart
        mark();
        push(1, 1, 0, 0, 4'd5); push(1, 1, 0, 0, 4'd4); push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd5;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        @(negedge clk);
        start = 1'b1; duration = 4'd9;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        check("abort_restart_ignored", int'(remaining), 5);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valve", int'(valve), 0);
        check("abort_remaining", int'(remaining), 0);
        repeat (6) @(negedge clk);
        #1;
        check("abort_valve_cycles", valve_cyc - v0, 6);
        check("abort_no_done", done_cyc - d0, 0);
        check("abort_queue_drained", exp_q.size(), 0);

        // Water loss coinciding with a prescaler wrap, duration 2
        mark();
        push(1, 1, 0, 0, 4'd2); push(0, 1, 1, 0, 4'd2); push(1, 1, 0, 0, 4'd2);
        push(1, 1, 0, 0, 4'd1); push(0, 0, 0, 0, 4'd0); push(0, 0, 0, 1, 4'd0);
        push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd2;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        repeat (3) @(negedge clk);
        water_ok = 1'b0;
        @(negedge clk);
        check("collide_remaining", int'(remaining), 2);
        check("collide_fault", int'(fault), 1);
        check("collide_busy", int'(busy), 1);
        water_ok = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("collide_done_pulses", done_cyc - d0, 1);
        check("collide_queue_drained", exp_q.size(), 0);

        // Reset mid-run, duration 4, then synchronised release
        mark();
        push(1, 1, 0, 0, 4'd4); push(0, 0, 0, 0, 4'd0);
        start = 1'b1; duration = 4'd4;
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("reset_async_valve", int'(valve), 0);
        check("reset_async_busy", int'(busy), 0);
        check("reset_async_remaining", int'(remaining), 0);
        repeat (2) @(negedge clk);
        check("reset_queue_drained", exp_q.size(), 0);
        push(1, 1, 0, 0, 4'd1); push(0, 0, 0, 0, 4'd0); push(0, 0, 0, 1, 4'd0);
        push(0, 0, 0, 0, 4'd0);
        rst = 1'b1; start = 1'b1; duration = 4'd1;
        @(negedge clk);
        check("release_edge1_valve", int'(valve), 0);
        check("release_edge1_remaining", int'(remaining), 0);
        @(negedge clk);
        check("release_edge2_valve", int'(valve), 0);
        @(negedge clk);
        start = 1'b0; duration = 4'd0;
        check("release_edge3_valve", int'(valve), 1);
        check("release_edge3_remaining", int'(remaining), 1);
        repeat (8) @(negedge clk);
        #1;
        check("release_done_pulses", done_cyc - d0, 1);
        check("final_queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
